// File: rtl/pm_pkg.sv
// pm_pkg: shared types and tile arithmetic for the player move scheduler.
//   state_t  sequencer states; dir_t decoded switch direction
//   tile_t   packed (x, y) tile coordinate
//   dir_of   switch priority up > right > down > left
//   next_tile  one-step move with tunnel wrap on both axes
//   addr_of  maze tile index y*gw + x
package pm_pkg;
  localparam int CW = 8;
  localparam int AW = 10;
  typedef logic [CW-1:0] coord_t;
  typedef struct packed {
    coord_t x;
    coord_t y;
  } tile_t;
  typedef enum logic [2:0] {IDLE, P0_REQ, P0_DAT, P1_REQ, P1_DAT} state_t;
  typedef enum logic [2:0] {NONE, UP, RIGHT, DOWN, LEFT} dir_t;
  function automatic dir_t dir_of(logic up, logic right, logic down, logic left);
    return up ? UP : right ? RIGHT : down ? DOWN : left ? LEFT : NONE;
  endfunction
  function automatic coord_t step(coord_t c, logic inc, logic dec, int n);
    return inc ? (c == coord_t'(n - 1) ? '0 : c + 1'b1)
         : dec ? (c == '0 ? coord_t'(n - 1) : c - 1'b1) : c;
  endfunction
  function automatic tile_t next_tile(tile_t t, dir_t d, int gw, int gh);
    return '{x: step(t.x, d == RIGHT, d == LEFT, gw), y: step(t.y, d == DOWN, d == UP, gh)};
  endfunction
  function automatic logic [AW-1:0] addr_of(tile_t t, int gw);
    return AW'(int'(t.y) * gw + int'(t.x));
  endfunction
endpackage

// File: rtl/player_move_scheduler_if.sv
// player_move_scheduler_if: maze tile read port shared with the renderer.
//   maze_rd_req  request, maze_addr held stable while high
//   maze_addr    tile index y*GRID_W + x
//   maze_rd_gnt  grant from the maze port arbiter
//   maze_wall    wall bit, valid the cycle after req&gnt is sampled
//   master = scheduler side, slave = arbiter/memory side
interface player_move_scheduler_if;
  logic                 maze_rd_req;
  logic [pm_pkg::AW-1:0] maze_addr;
  logic                 maze_rd_gnt;
  logic                 maze_wall;
  modport master(output maze_rd_req, maze_addr, input maze_rd_gnt, maze_wall);
  modport slave(input maze_rd_req, maze_addr, output maze_rd_gnt, maze_wall);
endinterface

// File: rtl/game_tick_divider.sv
// game_tick_divider: counts 0..TICK_DIV-1 and marks each wrap.
//   clock, reset  system clock, async active-high reset
//   wrap          combinational, high in the last count of the period
//   tick          registered one-cycle pulse following each wrap
module game_tick_divider #(
  parameter int TICK_DIV = 833333
) (
  input  logic clock,
  input  logic reset,
  output logic wrap,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  logic [W-1:0] cnt;
  assign wrap = cnt == W'(TICK_DIV - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= wrap ? '0 : cnt + 1'b1;
      tick <= wrap;
    end
endmodule

// File: rtl/player_move_scheduler.sv
// player_move_scheduler: per game tick, reads the maze wall bit for each player's
// target tile (player 0 then player 1) and commits or blocks the move.
//   clock, reset          system clock, async active-high reset
//   maze                  tile read port (master side)
//   up/right/down/left0/1 direction switches, sampled at the tick
//   player0/1_x/y         tile coordinates, zero-extended to 32 bits
//   tick                  one-cycle game tick pulse
//   busy                  sequencer not idle
//   collide               both players on one tile, refreshed while idle
//   tick_overrun          sticky, a tick arrived while busy and was dropped
//   POWERUP_EN adds powerup0_x/y inputs and powerup_hit/powerup_owner outputs.
module player_move_scheduler
  import pm_pkg::*;
#(
  parameter int TICK_DIV = 833333,
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int START0_X = 1,
  parameter int START0_Y = 1,
  parameter int START1_X = 30,
  parameter int START1_Y = 22
) (
  input  logic                    clock,
  input  logic                    reset,
  player_move_scheduler_if.master maze,
  input  logic                    up0,
  input  logic                    right0,
  input  logic                    down0,
  input  logic                    left0,
  input  logic                    up1,
  input  logic                    right1,
  input  logic                    down1,
  input  logic                    left1,
  output logic [31:0]             player0_x,
  output logic [31:0]             player0_y,
  output logic [31:0]             player1_x,
  output logic [31:0]             player1_y,
  output logic                    tick,
  output logic                    busy,
  output logic                    collide,
  output logic                    tick_overrun
`ifdef POWERUP_EN
  ,
  input  logic [31:0]             powerup0_x,
  input  logic [31:0]             powerup0_y,
  output logic                    powerup_hit,
  output logic                    powerup_owner
`endif
);
  localparam tile_t S0 = '{x: coord_t'(START0_X), y: coord_t'(START0_Y)};
  localparam tile_t S1 = '{x: coord_t'(START1_X), y: coord_t'(START1_Y)};
  state_t state;
  tile_t  p0, p1, tgt, n0, n1, m1;
  dir_t   nd0, nd1, d1;
  logic   wrap;
  assign nd0 = dir_of(up0, right0, down0, left0);
  assign nd1 = dir_of(up1, right1, down1, left1);
  assign n0  = next_tile(p0, nd0, GRID_W, GRID_H);
  assign n1  = next_tile(p1, nd1, GRID_W, GRID_H);
  // player 1 target from the direction latched at the tick
  assign m1  = next_tile(p1, d1, GRID_W, GRID_H);
  assign player0_x = 32'(p0.x);
  assign player0_y = 32'(p0.y);
  assign player1_x = 32'(p1.x);
  assign player1_y = 32'(p1.y);
`ifdef POWERUP_EN
  logic on_pu, got0;
  assign on_pu = powerup0_x == 32'(tgt.x) && powerup0_y == 32'(tgt.y);
`endif
  game_tick_divider #(.TICK_DIV(TICK_DIV)) u_div (.clock, .reset, .wrap, .tick);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state             <= IDLE;
      p0                <= S0;
      p1                <= S1;
      tgt               <= '0;
      d1                <= NONE;
      maze.maze_rd_req  <= 1'b0;
      maze.maze_addr    <= '0;
      busy              <= 1'b0;
      collide           <= 1'b0;
      tick_overrun      <= 1'b0;
`ifdef POWERUP_EN
      powerup_hit       <= 1'b0;
      powerup_owner     <= 1'b0;
      got0              <= 1'b0;
`endif
    end else begin
      if (wrap && state != IDLE) tick_overrun <= 1'b1;
`ifdef POWERUP_EN
      powerup_hit <= 1'b0;
`endif
      case (state)
        IDLE: begin
          collide <= p0 == p1;
          if (wrap && (nd0 != NONE || nd1 != NONE)) begin
            // a still player 0 goes straight to player 1's request
            state            <= nd0 != NONE ? P0_REQ : P1_REQ;
            tgt              <= nd0 != NONE ? n0 : n1;
            maze.maze_addr   <= addr_of(nd0 != NONE ? n0 : n1, GRID_W);
            maze.maze_rd_req <= 1'b1;
            busy             <= 1'b1;
            d1               <= nd1;
`ifdef POWERUP_EN
            got0             <= 1'b0;
`endif
          end
        end
        P0_REQ, P1_REQ:
          if (maze.maze_rd_gnt) begin
            state            <= state == P0_REQ ? P0_DAT : P1_DAT;
            maze.maze_rd_req <= 1'b0;
          end
        P0_DAT: begin
          if (!maze.maze_wall) p0 <= tgt;
`ifdef POWERUP_EN
          if (!maze.maze_wall && on_pu) begin
            powerup_hit   <= 1'b1;
            powerup_owner <= 1'b0;
            got0          <= 1'b1;
          end
`endif
          if (d1 != NONE) begin
            state            <= P1_REQ;
            tgt              <= m1;
            maze.maze_addr   <= addr_of(m1, GRID_W);
            maze.maze_rd_req <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        P1_DAT: begin
          if (!maze.maze_wall) p1 <= tgt;
`ifdef POWERUP_EN
          // player 0 keeps the powerup if both reach it on one tick
          if (!maze.maze_wall && on_pu && !got0) begin
            powerup_hit   <= 1'b1;
            powerup_owner <= 1'b1;
          end
`endif
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_player_move_scheduler.sv
// tb_player_move_scheduler: directed table of per-tick moves plus latency, stall,
// overrun, reset and powerup sequences.
module tb_player_move_scheduler;
  localparam int TD = 16;
  localparam logic [9:0] NO = 10'h3FF;
  localparam logic [7:0] U0 = 8'h80, R0 = 8'h40, D0 = 8'h20, L0 = 8'h10;
  localparam logic [7:0] U1 = 8'h08, R1 = 8'h04, D1 = 8'h02, L1 = 8'h01;
  typedef struct {
    logic [7:0] sw;
    logic [9:0] a0;
    logic [9:0] a1;
    int         x0, y0, x1, y1;
    logic       col;
  } vec_t;
  logic clock = 1'b0, reset = 1'b1, gnt = 1'b1;
  logic up0 = 0, right0 = 0, down0 = 0, left0 = 0, up1 = 0, right1 = 0, down1 = 0, left1 = 0;
  logic [31:0] player0_x, player0_y, player1_x, player1_y;
  logic tick, busy, collide, tick_overrun;
  int pass_n = 0, total_n = 0;
  vec_t tbl[15];
  player_move_scheduler_if mif();
  assign mif.maze_rd_gnt = gnt;
  // maze walls at tiles (1,0) and (0,23)
  assign mif.maze_wall = mif.maze_addr == 10'd1 || mif.maze_addr == 10'd736;
`ifdef POWERUP_EN
  logic [31:0] pu_x = 32'd31, pu_y = 32'd22;
  logic powerup_hit, powerup_owner;
`endif
  player_move_scheduler #(.TICK_DIV(TD)) dut (
    .clock(clock), .reset(reset), .maze(mif),
    .up0(up0), .right0(right0), .down0(down0), .left0(left0),
    .up1(up1), .right1(right1), .down1(down1), .left1(left1),
    .player0_x(player0_x), .player0_y(player0_y),
    .player1_x(player1_x), .player1_y(player1_y),
    .tick(tick), .busy(busy), .collide(collide), .tick_overrun(tick_overrun)
`ifdef POWERUP_EN
    , .powerup0_x(pu_x), .powerup0_y(pu_y),
    .powerup_hit(powerup_hit), .powerup_owner(powerup_owner)
`endif
  );
  always #5 clock = ~clock;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask
  task automatic set_sw(input logic [7:0] s);
    {up0, right0, down0, left0, up1, right1, down1, left1} = s;
  endtask
  task automatic wait_tick(input string name);
    bit seen;
    seen = 0;
    for (int k = 0; k < 3 * TD && !seen; k++) begin
      @(negedge clock);
      seen = tick;
    end
    chk({name, " tick"}, 32'(seen), 1);
  endtask
  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 40) begin
      @(negedge clock);
      k++;
    end
    chk({name, " done"}, 32'(k < 40), 1);
  endtask
  task automatic chk_pos(input string name, input int x0, input int y0, input int x1, input int y1);
    chk({name, " p0x"}, player0_x, x0);
    chk({name, " p0y"}, player0_y, y0);
    chk({name, " p1x"}, player1_x, x1);
    chk({name, " p1y"}, player1_y, y1);
  endtask
  task automatic run_row(input int i, input vec_t v);
    logic [9:0] seen[$];
    logic [9:0] want[$];
    string nm;
    bit pr;
    int k;
    nm = $sformatf("row%0d", i);
    set_sw(v.sw);
    wait_tick(nm);
    set_sw(8'h00);
    pr = 0;
    k = 0;
    while (k < 40) begin
      if (mif.maze_rd_req && !pr) seen.push_back(mif.maze_addr);
      pr = mif.maze_rd_req;
      if (!busy) break;
      @(negedge clock);
      k++;
    end
    chk({nm, " done"}, 32'(k < 40), 1);
    @(negedge clock);
    if (v.a0 != NO) want.push_back(v.a0);
    if (v.a1 != NO) want.push_back(v.a1);
    chk({nm, " nreq"}, seen.size(), want.size());
    for (int j = 0; j < want.size() && j < seen.size(); j++)
      chk($sformatf("%s addr%0d", nm, j), 32'(seen[j]), 32'(want[j]));
    chk_pos(nm, v.x0, v.y0, v.x1, v.y1);
    chk({nm, " collide"}, 32'(collide), 32'(v.col));
  endtask
  initial begin
    int ticks, reqs, bad;
    tbl[0]  = '{8'h00,             NO,    NO,     1,  1, 30, 22, 1'b0};
    tbl[1]  = '{U0,                10'd1, NO,     1,  1, 30, 22, 1'b0};
    tbl[2]  = '{R0,                10'd34, NO,    2,  1, 30, 22, 1'b0};
    tbl[3]  = '{R1,                NO, 10'd735,   2,  1, 31, 22, 1'b0};
    tbl[4]  = '{R1,                NO, 10'd704,   2,  1,  0, 22, 1'b0};
    tbl[5]  = '{D1,                NO, 10'd736,   2,  1,  0, 22, 1'b0};
    tbl[6]  = '{L1,                NO, 10'd735,   2,  1, 31, 22, 1'b0};
    tbl[7]  = '{U0|R0|D0|L0|D1,    10'd2, 10'd767, 2, 0, 31, 23, 1'b0};
    tbl[8]  = '{L0|D1,             10'd1, 10'd31,  2, 0, 31,  0, 1'b0};
    tbl[9]  = '{U0|R1,             10'd738, 10'd0, 2, 23, 0,  0, 1'b0};
    tbl[10] = '{D0|R1,             10'd2, 10'd1,   2,  0,  0,  0, 1'b0};
    tbl[11] = '{D0|D1,             10'd34, 10'd32, 2,  1,  0,  1, 1'b0};
    tbl[12] = '{L0|R1,             10'd33, 10'd33, 1,  1,  1,  1, 1'b1};
    tbl[13] = '{R0,                10'd34, NO,     2,  1,  1,  1, 1'b0};
    tbl[14] = '{U1|R1|D1|L1,       NO, 10'd1,      2,  1,  1,  1, 1'b0};
    set_sw(8'h00);
    repeat (3) @(negedge clock);
    chk_pos("reset", 1, 1, 30, 22);
    chk("reset tick", 32'(tick), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset collide", 32'(collide), 0);
    chk("reset overrun", 32'(tick_overrun), 0);
    chk("reset req", 32'(mif.maze_rd_req), 0);
    reset = 1'b0;
    ticks = 0;
    reqs = 0;
    repeat (2 * TD + 4) begin
      @(negedge clock);
      ticks += int'(tick);
      reqs += int'(mif.maze_rd_req);
    end
    chk("idle ticks", ticks, 2);
    chk("idle reqs", reqs, 0);
    chk_pos("idle", 1, 1, 30, 22);
    for (int i = 0; i < 15; i++) run_row(i, tbl[i]);
    set_sw(R0);
    wait_tick("lat");
    set_sw(8'h00);
    chk("lat req", 32'(mif.maze_rd_req), 1);
    chk("lat addr", 32'(mif.maze_addr), 35);
    chk("lat busy", 32'(busy), 1);
    chk("lat x0", player0_x, 2);
    @(negedge clock);
    chk("lat req1", 32'(mif.maze_rd_req), 0);
    chk("lat x1", player0_x, 2);
    @(negedge clock);
    chk("lat x2", player0_x, 3);
    chk("lat busy2", 32'(busy), 0);
    gnt = 1'b0;
    set_sw(R0);
    wait_tick("stall");
    set_sw(8'h00);
    bad = 0;
    repeat (10) begin
      if (!(mif.maze_rd_req && mif.maze_addr == 10'd36 && busy)) bad++;
      @(negedge clock);
    end
    chk("stall stable", bad, 0);
    chk("stall x", player0_x, 3);
    gnt = 1'b1;
    @(negedge clock);
    chk("stall dat req", 32'(mif.maze_rd_req), 0);
    chk("stall dat x", player0_x, 3);
    @(negedge clock);
    chk("stall commit x", player0_x, 4);
    chk("stall overrun", 32'(tick_overrun), 0);
    gnt = 1'b0;
    set_sw(R0);
    wait_tick("ovr");
    set_sw(8'h00);
    repeat (20) @(negedge clock);
    chk("ovr flag", 32'(tick_overrun), 1);
    chk("ovr busy", 32'(busy), 1);
    chk("ovr req", 32'(mif.maze_rd_req), 1);
    chk("ovr x", player0_x, 4);
    gnt = 1'b1;
    wait_idle("ovr");
    chk("ovr commit x", player0_x, 5);
    wait_tick("ovr next");
    repeat (3) @(negedge clock);
    chk("ovr sticky", 32'(tick_overrun), 1);
    chk("ovr once x", player0_x, 5);
    chk("ovr idle", 32'(busy), 0);
    set_sw(R1);
    wait_tick("rst");
    set_sw(8'h00);
    chk("rst p1req", 32'(mif.maze_rd_req), 1);
    chk("rst addr", 32'(mif.maze_addr), 34);
    @(negedge clock);
    chk("rst p1dat req", 32'(mif.maze_rd_req), 0);
    chk("rst p1dat busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    chk_pos("rst async", 1, 1, 30, 22);
    chk("rst busy", 32'(busy), 0);
    chk("rst overrun", 32'(tick_overrun), 0);
    chk("rst tick", 32'(tick), 0);
    chk("rst req", 32'(mif.maze_rd_req), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk_pos("rst after", 1, 1, 30, 22);
    chk("rst after busy", 32'(busy), 0);
`ifdef POWERUP_EN
    set_sw(R1);
    wait_tick("pu1");
    set_sw(8'h00);
    ticks = 0;
    repeat (6) begin
      ticks += int'(powerup_hit);
      @(negedge clock);
    end
    chk("pu1 hits", ticks, 1);
    chk("pu1 owner", 32'(powerup_owner), 1);
    pu_x = 32'd2;
    pu_y = 32'd1;
    set_sw(R0);
    wait_tick("pu0");
    set_sw(8'h00);
    ticks = 0;
    repeat (6) begin
      ticks += int'(powerup_hit);
      @(negedge clock);
    end
    chk("pu0 hits", ticks, 1);
    chk("pu0 owner", 32'(powerup_owner), 0);
`endif
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
